// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: N-way set-associative write-back write-allocate data cache controller with LRU and flush
module sa_cache_ctrl #(
  parameter int BLOCK_WORDS = 8,
  parameter int SETS        = 64,
  parameter int ASSOC       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        flush_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam int AGE_W = $clog2(ASSOC);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t st;
  logic [31:0] data [SETS][ASSOC][BLOCK_WORDS];
  logic [TAG_W-1:0] tags [SETS][ASSOC];
  logic [AGE_W-1:0] age [SETS][ASSOC];
  logic [ASSOC-1:0] valid [SETS];
  logic [ASSOC-1:0] dirty [SETS];
  logic [31:2] ra;
  logic rwe;
  logic [31:0] rwd;
  logic [3:0] rbe;
  logic [IDX_W-1:0] idx, fset, bset;
  logic [OFF_W-1:0] off, cnt, ncnt;
  logic [TAG_W-1:0] tag, btag;
  logic [AGE_W-1:0] vway, fway, bway, hway, iway, oway, victim, hage;
  logic hit, inv;
  logic [31:0] cur, merged, a0, a1;
  logic unused;
  assign unused = ^cpu_addr[1:0];
  assign off = ra[OFF_W+1:2];
  assign idx = ra[IDX_W+OFF_W+1:OFF_W+2];
  assign tag = ra[31:IDX_W+OFF_W+2];
  always_comb begin
    hit = 1'b0;
    inv = 1'b0;
    hway = '0;
    iway = '0;
    oway = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hway = AGE_W'(w);
      end
      if (!valid[idx][w]) begin
        inv = 1'b1;
        iway = AGE_W'(w);
      end
      if (age[idx][w] == AGE_W'(ASSOC - 1)) oway = AGE_W'(w);
    end
    victim = inv ? iway : oway;
    hage = age[idx][hway];
    cur = data[idx][hway][off];
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = rbe[b] ? rwd[8*b +: 8] : cur[8*b +: 8];
  end
  // Beat source: flush walks its own set/way; eviction and refill use the latched request.
  always_comb begin
    bset = (st == FLUSH_WB) ? fset : idx;
    bway = (st == FLUSH_WB) ? fway : vway;
    btag = (st == REFILL) ? tag : tags[bset][bway];
    ncnt = cnt + OFF_W'(1);
    a0 = {btag, bset, cnt, 2'b00};
    a1 = {btag, bset, ncnt, 2'b00};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      flush_done <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      fset <= '0;
      fway <= '0;
      vway <= '0;
      ra <= '0;
      rwe <= 1'b0;
      rwd <= '0;
      rbe <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < ASSOC; w++) age[s][w] <= AGE_W'(w);
      end
    end else begin
      cpu_ready <= 1'b0;
      flush_done <= 1'b0;
      case (st)
        IDLE: begin
          if (flush) begin
            fset <= '0;
            fway <= '0;
            st <= FLUSH_SCAN;
          end else if (cpu_req && !cpu_ready) begin
            ra <= cpu_addr[31:2];
            rwe <= cpu_we;
            rwd <= cpu_wdata;
            rbe <= cpu_be;
            st <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            st <= IDLE;
            if (!rwe) cpu_rdata <= cur;
            else begin
              data[idx][hway][off] <= merged;
              if (|rbe) dirty[idx][hway] <= 1'b1;
            end
            for (int w = 0; w < ASSOC; w++)
              age[idx][w] <= (AGE_W'(w) == hway) ? '0 :
                             (age[idx][w] < hage) ? age[idx][w] + AGE_W'(1) : age[idx][w];
          end else begin
            vway <= victim;
            cnt <= '0;
            st <= (valid[idx][victim] && dirty[idx][victim]) ? WB : REFILL;
          end
        end
        WB, REFILL, FLUSH_WB: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we <= st != REFILL;
            mem_addr <= a0;
            mem_wdata <= (st == REFILL) ? '0 : data[bset][bway][cnt];
          end else if (mem_ack) begin
            cnt <= ncnt;
            if (st == REFILL) data[idx][vway][cnt] <= mem_rdata;
            if (&cnt) begin
              mem_req <= 1'b0;
              mem_we <= 1'b0;
              if (st == REFILL) begin
                valid[idx][vway] <= 1'b1;
                tags[idx][vway] <= tag;
                dirty[idx][vway] <= 1'b0;
                st <= LOOKUP;
              end else begin
                dirty[bset][bway] <= 1'b0;
                st <= (st == WB) ? REFILL : FLUSH_SCAN;
              end
            end else begin
              mem_addr <= a1;
              mem_wdata <= (st == REFILL) ? '0 : data[bset][bway][ncnt];
            end
          end
        end
        FLUSH_SCAN: begin
          if (valid[fset][fway] && dirty[fset][fway]) begin
            cnt <= '0;
            st <= FLUSH_WB;
          end else begin
            valid[fset][fway] <= 1'b0;
            dirty[fset][fway] <= 1'b0;
            age[fset][fway] <= fway;
            fway <= fway + AGE_W'(1);
            if (&fway) fset <= fset + IDX_W'(1);
            if (&fway && &fset) begin
              flush_done <= 1'b1;
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
